// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: fetches one bitplane per row from BRAM,
// shifts it out, latches it and displays it for a binary-weighted time.
module hub75_scan_ctrl #(
   parameter int FIFO_WIDTH = 64,
   parameter int ADDR_WIDTH = 8,
   parameter int ROWS       = 32,
   parameter int PLANES     = 8,
   parameter int BASE_ON    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   output logic                    bram_re,
   output logic [ADDR_WIDTH-1:0]   bram_addr,
   input  logic [FIFO_WIDTH-1:0]   bram_red_0,
   input  logic [FIFO_WIDTH-1:0]   bram_green_0,
   input  logic [FIFO_WIDTH-1:0]   bram_blue_0,
   input  logic [FIFO_WIDTH-1:0]   bram_red_1,
   input  logic [FIFO_WIDTH-1:0]   bram_green_1,
   input  logic [FIFO_WIDTH-1:0]   bram_blue_1,
   output logic                    hub_r0,
   output logic                    hub_g0,
   output logic                    hub_b0,
   output logic                    hub_r1,
   output logic                    hub_g1,
   output logic                    hub_b1,
   output logic                    hub_clk,
   output logic                    hub_lat,
   output logic                    hub_oe_n,
   output logic [$clog2(ROWS)-1:0] hub_row,
   output logic                    frame_done
);

   localparam int RW       = $clog2(ROWS);
   localparam int PW       = (PLANES > 1) ? $clog2(PLANES) : 1;
   localparam int CW       = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
   localparam int DISP_MAX = BASE_ON << (PLANES - 1);
   localparam int DW       = $clog2(DISP_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
   } state_t;

   function automatic logic [ADDR_WIDTH-1:0] fetch_addr(input int r, input int p);
      return ADDR_WIDTH'(r * PLANES + p);
   endfunction

   function automatic logic [DW-1:0] disp_len(input int p);
      return DW'((BASE_ON << p) - 1);
   endfunction

   state_t                       state_q;
   logic [RW-1:0]                row_q;
   logic [PW-1:0]                plane_q;
   logic [CW-1:0]                col_q;
   logic [DW-1:0]                disp_q;
   logic [5:0][FIFO_WIDTH-1:0]   sr_q;
   logic [5:0]                   data_q;
   logic                         frame_ready_q, bram_re_q, hub_clk_q, hub_lat_q, hub_oe_n_q, frame_done_q;
   logic [ADDR_WIDTH-1:0]        bram_addr_q;
   logic [RW-1:0]                hub_row_q;

   logic [5:0][FIFO_WIDTH-1:0]   words_d;
   logic                         last_plane_d, last_row_d, last_col_d;
   logic [ADDR_WIDTH-1:0]        next_addr_d;

   always_comb begin
      words_d      = {bram_red_0, bram_green_0, bram_blue_0, bram_red_1, bram_green_1, bram_blue_1};
      last_plane_d = (plane_q == PW'(PLANES - 1));
      last_row_d   = (row_q == RW'(ROWS - 1));
      last_col_d   = (col_q == CW'(FIFO_WIDTH - 1));
      next_addr_d  = last_plane_d ? fetch_addr(int'(row_q) + 1, 0)
                                  : fetch_addr(int'(row_q), int'(plane_q) + 1);
   end

   // Shift registers hold the not-yet-driven pixels; bit 0 goes out first.
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD) begin
         for (int c = 0; c < 6; c++) sr_q[c] <= words_d[c] >> 1;
      end else if (state_q == S_SHIFT && hub_clk_q && !last_col_d) begin
         for (int c = 0; c < 6; c++) sr_q[c] <= sr_q[c] >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         row_q         <= '0;
         plane_q       <= '0;
         col_q         <= '0;
         disp_q        <= '0;
         data_q        <= '0;
         frame_ready_q <= 1'b0;
         bram_re_q     <= 1'b0;
         bram_addr_q   <= '0;
         hub_clk_q     <= 1'b0;
         hub_lat_q     <= 1'b0;
         hub_oe_n_q    <= 1'b1;
         hub_row_q     <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (frame_valid) begin
                  state_q       <= S_FETCH;
                  row_q         <= '0;
                  plane_q       <= '0;
                  frame_ready_q <= 1'b0;
                  bram_re_q     <= 1'b1;
                  bram_addr_q   <= '0;
               end else begin
                  frame_ready_q <= 1'b1;
               end
            end
            S_FETCH: begin
               bram_re_q <= 1'b0;
               state_q   <= S_LOAD;
            end
            S_LOAD: begin
               for (int c = 0; c < 6; c++) data_q[c] <= words_d[c][0];
               col_q   <= '0;
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               // hub_clk doubles as the pixel phase: low half, then high half.
               if (!hub_clk_q) begin
                  hub_clk_q <= 1'b1;
               end else begin
                  hub_clk_q <= 1'b0;
                  if (last_col_d) begin
                     state_q <= S_BLANK;
                  end else begin
                     col_q <= col_q + CW'(1);
                     for (int c = 0; c < 6; c++) data_q[c] <= sr_q[c][0];
                  end
               end
            end
            S_BLANK: begin
               hub_lat_q <= 1'b1;
               hub_row_q <= row_q;
               state_q   <= S_LATCH;
            end
            S_LATCH: begin
               hub_lat_q  <= 1'b0;
               hub_oe_n_q <= 1'b0;
               disp_q     <= disp_len(int'(plane_q));
               state_q    <= S_DISPLAY;
            end
            S_DISPLAY: begin
               if (disp_q != '0) begin
                  disp_q <= disp_q - DW'(1);
               end else begin
                  hub_oe_n_q <= 1'b1;
                  if (!last_plane_d || !last_row_d) begin
                     plane_q     <= last_plane_d ? '0 : plane_q + PW'(1);
                     row_q       <= last_plane_d ? row_q + RW'(1) : row_q;
                     bram_re_q   <= 1'b1;
                     bram_addr_q <= next_addr_d;
                     state_q     <= S_FETCH;
                  end else begin
                     // The done cycle is spent in IDLE, where frame_valid decides what follows.
                     row_q         <= '0;
                     plane_q       <= '0;
                     frame_done_q  <= 1'b1;
                     frame_ready_q <= 1'b1;
                     state_q       <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign frame_ready = frame_ready_q;
   assign bram_re     = bram_re_q;
   assign bram_addr   = bram_addr_q;
   assign hub_r0      = data_q[5];
   assign hub_g0      = data_q[4];
   assign hub_b0      = data_q[3];
   assign hub_r1      = data_q[2];
   assign hub_g1      = data_q[1];
   assign hub_b1      = data_q[0];
   assign hub_clk     = hub_clk_q;
   assign hub_lat     = hub_lat_q;
   assign hub_oe_n    = hub_oe_n_q;
   assign hub_row     = hub_row_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: random BRAM contents and frame_valid traffic,
// every cycle compared against a timeline model built from the frame arithmetic.
module tb_hub75_scan_ctrl;

   localparam int W    = 16;
   localparam int AW   = 5;
   localparam int R    = 8;
   localparam int P    = 4;
   localparam int B    = 3;
   localparam int RWID = $clog2(R);

   localparam int M_RST   = 0;
   localparam int M_IDLE  = 1;
   localparam int M_DONE  = 2;
   localparam int M_FRAME = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frame_valid = 1'b0;
   logic frame_ready, bram_re, hub_clk, hub_lat, hub_oe_n, frame_done;
   logic hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
   logic [AW-1:0]   bram_addr;
   logic [RWID-1:0] hub_row;
   logic [W-1:0]    rd [6];
   logic [W-1:0]    mem [6][R*P];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int m_mode = M_RST;
   int m_t = 0;
   int m_hubrow = 0;
   int m_frames = 0;
   int m_rise = 0;
   int obs_done = 0;
   int obs_rise = 0;
   logic prev_clk = 1'b0;

   hub75_scan_ctrl #(
      .FIFO_WIDTH(W), .ADDR_WIDTH(AW), .ROWS(R), .PLANES(P), .BASE_ON(B)
   ) dut (
      .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .bram_re(bram_re), .bram_addr(bram_addr),
      .bram_red_0(rd[0]), .bram_green_0(rd[1]), .bram_blue_0(rd[2]),
      .bram_red_1(rd[3]), .bram_green_1(rd[4]), .bram_blue_1(rd[5]),
      .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
      .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
      .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
      .hub_row(hub_row), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Synchronous BRAM: data appears the cycle after the read enable.
   always @(posedge clk) begin
      if (bram_re) for (int c = 0; c < 6; c++) rd[c] <= mem[c][bram_addr];
   end

   function automatic int seg_len(input int p);
      return 4 + 2 * W + (B << p);
   endfunction

   function automatic int row_len();
      int s = 0;
      for (int p = 0; p < P; p++) s += seg_len(p);
      return s;
   endfunction

   task automatic decode(input int t, output int row, output int pl, output int off);
      row = t / row_len();
      off = t % row_len();
      pl  = 0;
      while (off >= seg_len(pl)) begin
         off -= seg_len(pl);
         pl++;
      end
   endtask

   task automatic finish_bench();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
         if (failures >= 40) finish_bench();
      end
   endtask

   task automatic randomize_mem();
      for (int c = 0; c < 6; c++)
         for (int a = 0; a < R * P; a++) mem[c][a] = W'($urandom);
   endtask

   // ctl bits: {bram_re, hub_oe_n, hub_lat, hub_clk, frame_done, frame_ready}
   task automatic step(input logic r, input logic fv);
      logic [5:0] ectl, edata;
      logic [AW-1:0] eaddr;
      bit ca, cd;
      int row, pl, off, s, a;
      @(negedge clk);
      cyc++;
      ectl = 6'b010000; edata = '0; eaddr = '0; ca = 0; cd = 0;
      case (m_mode)
         M_RST: begin
            ca = 1; cd = 1; m_hubrow = 0;
         end
         M_IDLE: ectl[0] = 1'b1;
         M_DONE: ectl[1:0] = 2'b11;
         default: begin
            decode(m_t, row, pl, off);
            a = row * P + pl;
            if (off == 0) begin
               ectl[5] = 1'b1; ca = 1; eaddr = AW'(a);
            end else if (off >= 2 && off < 2 + 2 * W) begin
               s = off - 2;
               ectl[2] = 1'(s % 2);
               if (s % 2 == 1) m_rise++;
               cd = 1;
               for (int c = 0; c < 6; c++) edata[5-c] = mem[c][a][s/2];
            end else if (off == 3 + 2 * W) begin
               ectl[3] = 1'b1; m_hubrow = row;
            end else if (off > 3 + 2 * W) begin
               ectl[4] = 1'b0;
            end
         end
      endcase
      chk("ctl", 32'({bram_re, hub_oe_n, hub_lat, hub_clk, frame_done, frame_ready}), 32'(ectl));
      chk("hub_row", 32'(hub_row), 32'(m_hubrow));
      if (ca) chk("bram_addr", 32'(bram_addr), 32'(eaddr));
      if (cd) chk("hub_data", 32'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1}), 32'(edata));
      if (frame_done) obs_done++;
      if (hub_clk && !prev_clk) obs_rise++;
      prev_clk = hub_clk;
      rst = r;
      frame_valid = fv;
      if (r) begin
         m_mode = M_RST;
      end else if (m_mode == M_FRAME) begin
         m_t++;
         if (m_t == R * row_len()) begin
            m_mode = M_DONE;
            m_frames++;
         end
      end else if (fv) begin
         m_mode = M_FRAME;
         m_t = 0;
      end else begin
         m_mode = M_IDLE;
      end
   endtask

   // Runs the current frame to its end with random frame_valid noise, then
   // decides back-to-back versus idle in the done cycle.
   task automatic run_frame(input logic b2b);
      while (m_mode == M_FRAME) step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, b2b);
   endtask

   initial begin
      int row, pl, off;
      randomize_mem();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      step(1'b0, 1'b1);
      run_frame(1'b1);
      run_frame(1'b0);
      repeat (4) step(1'b0, 1'b0);

      randomize_mem();
      step(1'b0, 1'b1);
      row = 0; pl = 0; off = 0;
      while (!(m_mode == M_FRAME && row == 2 && off == 2 + W)) begin
         step(1'b0, 1'($urandom_range(0, 1)));
         if (m_mode == M_FRAME) decode(m_t, row, pl, off);
      end
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      randomize_mem();
      step(1'b0, 1'b1);
      run_frame(1'b0);
      repeat (3) step(1'b0, 1'b0);

      chk("frame_done_count", 32'(obs_done), 32'(m_frames));
      chk("hub_clk_rises", 32'(obs_rise), 32'(m_rise));
      finish_bench();
   end

endmodule
